mac_lane_array: RTL
===================

Name: mac_lane_array

Overview:
Parametrised multi-lane multiply-accumulate engine, the next generation of the two-lane byte-loaded MAC. Operands arrive on one byte-wide valid/ready stream, and each lane accumulates a runtime-programmed number of products. At the end of the run each lane's accumulator is scaled by a fixed right shift, saturated to DW bits, and emitted lane by lane on a valid/ready output stream. The block sits between the operand loader and the serializer/activation stage of the matrix-multiply datapath.

Parameters:
LANES, 2, number of parallel MAC lanes (1..8)
DW, 8, operand and output data width
ACCW, 2*DW+8, accumulator width; guarantees no overflow for 255 unsigned steps
OUT_SHIFT, 9, right shift applied to the accumulator before saturation
SIGNED, 0, 0 = unsigned arithmetic; 1 = two's-complement operands, accumulator and saturation

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a run; accepted only in IDLE
cfg_len  input  8  number of accumulate steps; sampled on accepted start
in_valid  input  1  operand byte valid
in_data  input  DW  operand byte
in_ready  output  1  operand byte accepted when in_valid && in_ready
out_valid  output  1  result word valid
out_data  output  DW  scaled, saturated lane result
out_ready  input  1  downstream accepts the word when out_valid && out_ready
out_last  output  1  high with the word from lane LANES-1
busy  output  1  high in every state except IDLE
sat_flag  output  1  sticky: some lane saturated in this run; cleared on accepted start

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE. All operand, product and accumulator registers clear to 0. in_ready, out_valid, out_last, busy, sat_flag and out_data are all 0. Reset mid-run abandons the run; no partial output is produced.
- FSM states: IDLE, LOAD, FLUSH, EMIT.
- IDLE -> LOAD on start when cfg_len != 0. On that transition the accumulators and sat_flag clear, step_cnt=0 and byte_cnt=0.
- IDLE -> FLUSH on start when cfg_len == 0. The accumulators clear, so EMIT outputs LANES zero words.
- start while busy is ignored.
- LOAD:
  - in_ready = 1.
  - Byte order per step: lane0.a, lane0.b, lane1.a, lane1.b, ... (2*LANES bytes per step).
  - byte_cnt advances only on accepted bytes; bubbles are allowed.
  - Each accepted byte is written into its lane's operand register.
  - Acceptance of the final byte of a step raises a fire pulse and increments step_cnt.
  - When step_cnt reaches cfg_len, the FSM moves to FLUSH.
- MAC pipeline per lane:
  - Edge E0 (final byte accepted): operands registered, fire pulse.
  - E1: product register = a*b (2*DW bits).
  - E2: accumulator += product, sign- or zero-extended to ACCW.
- FLUSH: in_ready = 0. The FSM waits two cycles for the pipeline to drain, then enters EMIT.
- Latency: out_valid rises 3 clock edges after the edge that accepted the final operand byte.
- EMIT:
  - Results are emitted in order lane 0 .. LANES-1.
  - out_data = sat(acc >> OUT_SHIFT), using arithmetic shift when SIGNED=1.
  - Unsigned saturation: clamp to 2^DW-1. Signed saturation: clamp to [-2^(DW-1), 2^(DW-1)-1].
  - Any clamp sets sat_flag.
  - out_valid holds and out_data/out_last stay stable until out_ready.
  - The handshake on lane LANES-1 (out_last=1) returns the FSM to IDLE.
- A start arriving in the same cycle as the final EMIT handshake is ignored; start is accepted from IDLE only.
- in_valid outside LOAD is ignored; no byte is consumed.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE/LOAD/FLUSH/EMIT);
  - the default DW/ACCW/OUT_SHIFT constants;
  - a saturating-shift function.
- One sub-module, mac_lane, holds per-lane logic:
  - operand a/b registers;
  - product register;
  - accumulator with synchronous clear and fire enable;
  - scaled/saturated result plus saturation indication.
- The top level owns the FSM, the byte/step/lane counters and the output handshake, and instantiates LANES copies of mac_lane.

Test Plan:
1. Defaults, cfg_len=1, bytes 255,255,16,32 -> out_data 127 then 1 (out_last on 1); sat_flag=0; out_valid 3 edges after the last byte.
2. cfg_len=4, each step lane0 200*200, lane1 10*10 -> lane0 160000>>9=312 clamps to 255 with sat_flag=1; lane1 400>>9=0.
3. Test 1 stimulus with out_ready low for 5 cycles -> out_valid stays 1 and out_data holds 127; sequence completes after out_ready rises.
4. Random in_valid bubbles with cfg_len=3 -> results identical to the bubble-free run; in_ready=0 throughout FLUSH and EMIT.
5. rst_n pulsed low mid-LOAD -> all outputs and busy go 0 immediately; a fresh start with the test 1 stimulus yields 127, 1.
6. cfg_len=0 -> outputs 0, 0; a start pulsed while busy is ignored (exactly LANES words per run); SIGNED=1 with -128*-128, cfg_len=1 -> 16384>>9=32.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the multi-lane MAC engine: FSM state encoding,
// default widths and the scale-then-saturate function used by every lane.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, EMIT} state_t;

  localparam int DW_DEF        = 8;
  localparam int ACCW_DEF      = 2 * DW_DEF + 8;
  localparam int OUT_SHIFT_DEF = 9;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Arithmetic right shift, then clamp into the DW-bit output range.
  function automatic sat_res_t sat_shift(input logic signed [63:0] acc, input int shift,
                                         input int dw, input bit is_signed);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    sh = acc >>> shift;
    if (is_signed) begin
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
    end else begin
      hi = (64'sd1 <<< dw) - 64'sd1;
      lo = 64'sd0;
    end
    r.sat = (sh > hi) || (sh < lo);
    r.val = (sh > hi) ? hi : ((sh < lo) ? lo : sh);
    return r;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: operand capture, registered product, accumulator with
// synchronous clear, and the scaled/saturated result for the output stage.
module mac_lane
  import mac_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int ACCW      = ACCW_DEF,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF,
  parameter int SIGNED    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we_a,
  input  logic          we_b,
  input  logic          fire,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] res,
  output logic          sat
);

  localparam bit SGN = (SIGNED != 0);

  logic        [DW-1:0]   a_p0;
  logic        [DW-1:0]   b_p0;
  logic                   vld_p0;
  logic signed [2*DW-1:0] a_w;
  logic signed [2*DW-1:0] b_w;
  logic signed [2*DW-1:0] prod_w;
  logic signed [2*DW-1:0] prod_p1;
  logic                   vld_p1;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_p2;
  logic signed [63:0]     acc_w;
  sat_res_t               sr;

  // Operands widened to the product width so a single multiply serves both modes.
  assign a_w      = {{DW{SGN & a_p0[DW-1]}}, a_p0};
  assign b_w      = {{DW{SGN & b_p0[DW-1]}}, b_p0};
  assign prod_w   = a_w * b_w;
  assign prod_ext = {{(ACCW-2*DW){SGN & prod_p1[2*DW-1]}}, prod_p1};
  assign acc_w    = {{(64-ACCW){SGN & acc_p2[ACCW-1]}}, acc_p2};
  assign sr       = sat_shift(acc_w, OUT_SHIFT, DW, SGN);
  assign res      = DW'(sr.val);
  assign sat      = sr.sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0    <= '0;
      b_p0    <= '0;
      vld_p0  <= 1'b0;
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
    end else begin
      // p0: operand capture; fire marks the last byte of a step
      if (we_a) a_p0 <= din;
      if (we_b) b_p0 <= din;
      vld_p0 <= fire;
      // p1: product
      vld_p1 <= vld_p0;
      if (vld_p0) prod_p1 <= prod_w;
      // p2: accumulate
      if (clr)         acc_p2 <= '0;
      else if (vld_p1) acc_p2 <= acc_p2 + prod_ext;
    end
  end

endmodule

// File: rtl/mac_lane_array.sv
// Multi-lane MAC engine: byte-serial operand loading, per-lane accumulation,
// then lane-by-lane emission of scaled, saturated results.
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int DW        = DW_DEF,
  parameter int ACCW      = ACCW_DEF,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF,
  parameter int SIGNED    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    cfg_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          sat_flag
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW = $clog2(2 * LANES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(2 * LANES - 1);

  state_t           state;
  logic [BW-1:0]    byte_cnt;
  logic [7:0]       step_cnt;
  logic [7:0]       len_q;
  logic [1:0]       flush_cnt;
  logic [LW-1:0]    lane_idx;
  logic [LW-1:0]    nxt_lane;
  logic             accept;
  logic             acc_clr;
  logic [DW-1:0]    lane_res [LANES];
  logic [LANES-1:0] lane_sat;

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign acc_clr  = start && (state == IDLE);
  assign nxt_lane = lane_idx + LW'(1);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    mac_lane #(
      .DW       (DW),
      .ACCW     (ACCW),
      .OUT_SHIFT(OUT_SHIFT),
      .SIGNED   (SIGNED)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (acc_clr),
      .we_a (accept && (byte_cnt == BW'(2 * gi))),
      .we_b (accept && (byte_cnt == BW'(2 * gi + 1))),
      .fire (accept && (byte_cnt == LAST_BYTE)),
      .din  (in_data),
      .res  (lane_res[gi]),
      .sat  (lane_sat[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      step_cnt  <= '0;
      len_q     <= '0;
      flush_cnt <= '0;
      lane_idx  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= cfg_len;
            step_cnt  <= '0;
            byte_cnt  <= '0;
            flush_cnt <= '0;
            sat_flag  <= 1'b0;
            state     <= (cfg_len == 8'd0) ? FLUSH : LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              step_cnt <= step_cnt + 8'd1;
              if (step_cnt + 8'd1 == len_q) begin
                state     <= FLUSH;
                flush_cnt <= '0;
              end
            end else begin
              byte_cnt <= byte_cnt + BW'(1);
            end
          end
        end
        // The final accumulate lands two edges after the last byte; the lane
        // results are stable by the third edge, where the first word is loaded.
        FLUSH: begin
          if (flush_cnt == 2'd2) begin
            state     <= EMIT;
            lane_idx  <= '0;
            out_valid <= 1'b1;
            out_data  <= lane_res[0];
            out_last  <= (LANES == 1);
            sat_flag  <= sat_flag | lane_sat[0];
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              lane_idx <= nxt_lane;
              out_data <= lane_res[nxt_lane];
              out_last <= (nxt_lane == LW'(LANES - 1));
              sat_flag <= sat_flag | lane_sat[nxt_lane];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
